// File: rtl/serial_uart_bridge_if.sv
// serial_uart_bridge_if: processor-side byte port between the host and the UART bridge
interface serial_uart_bridge_if;
  logic [7:0] host_wr_data;
  logic       host_wren;
  logic       host_rden;
  logic [7:0] host_rd_data;
  logic       host_valid;
  logic       host_ready;
  modport master(output host_wr_data, host_wren, host_rden, input host_rd_data, host_valid, host_ready);
  modport slave(input host_wr_data, host_wren, host_rden, output host_rd_data, host_valid, host_ready);
endinterface

// File: rtl/serial_uart_bridge.sv
// serial_uart_bridge: host byte port to 8N1 UART with TX/RX FIFOs
module serial_uart_bridge #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                clock,
  input  logic                reset,
  serial_uart_bridge_if.slave host,
  input  logic                uart_rx,
  output logic                uart_tx,
  output logic                rx_overrun,
  output logic                rx_frame_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [AW:0]   L_DEPTH    = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] L_BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] L_HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [1:0] TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3;
  localparam logic [2:0] RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2, RX_STOP = 3'd3, RX_WAIT = 3'd4;
  logic [7:0]    r_tx_mem [FIFO_DEPTH];
  logic [AW-1:0] r_tx_wp, r_tx_rp;
  logic [AW:0]   r_tx_cnt;
  logic [1:0]    r_tx_state;
  logic [CW-1:0] r_tx_clk;
  logic [2:0]    r_tx_bit;
  logic [7:0]    r_tx_sh;
  logic          r_uart_tx;
  logic [7:0]    r_rx_mem [FIFO_DEPTH];
  logic [AW-1:0] r_rx_wp, r_rx_rp;
  logic [AW:0]   r_rx_cnt;
  logic [2:0]    r_rx_state;
  logic [CW-1:0] r_rx_clk;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_sh;
  logic          r_rx_s1, r_rx_s2;
  logic          r_rx_overrun, r_rx_ferr;
  logic          w_tx_push, w_tx_pop, w_tx_tick;
  logic          w_rx_push, w_rx_pop, w_rx_samp, w_rx_stop;
  assign host.host_ready   = r_tx_cnt < L_DEPTH;
  assign host.host_valid   = r_rx_cnt != '0;
  assign host.host_rd_data = host.host_valid ? r_rx_mem[r_rx_rp] : 8'h00;
  assign uart_tx      = r_uart_tx;
  assign rx_overrun   = r_rx_overrun;
  assign rx_frame_err = r_rx_ferr;
  assign w_tx_push = host.host_wren && host.host_ready;
  assign w_tx_pop  = (r_tx_state == TX_IDLE) && (r_tx_cnt != '0);
  assign w_tx_tick = r_tx_clk == L_BIT_END;
  assign w_rx_samp = (r_rx_state == RX_START) ? (r_rx_clk == L_HALF_END) : (r_rx_clk == L_BIT_END);
  assign w_rx_stop = (r_rx_state == RX_STOP) && w_rx_samp;
  assign w_rx_pop  = host.host_rden && host.host_valid;
  assign w_rx_push = w_rx_stop && r_rx_s2 && (r_rx_cnt < L_DEPTH || w_rx_pop);
  // TX FIFO storage, written by the host
  always_ff @(posedge clock)
    if (w_tx_push) r_tx_mem[r_tx_wp] <= host.host_wr_data;
  // TX FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + AW'(1);
      if (w_tx_pop) r_tx_rp <= r_tx_rp + AW'(1);
      r_tx_cnt <= r_tx_cnt + (AW+1)'(w_tx_push) - (AW+1)'(w_tx_pop);
    end
  end
  // TX serialiser: start bit, 8 data bits LSB first, stop bit, one idle cycle between frames
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_clk   <= '0;
      r_tx_bit   <= '0;
      r_tx_sh    <= '0;
      r_uart_tx  <= 1'b1;
    end else begin
      r_tx_clk <= (r_tx_state == TX_IDLE || w_tx_tick) ? '0 : r_tx_clk + CW'(1);
      case (r_tx_state)
        TX_IDLE: if (w_tx_pop) begin
          r_tx_sh    <= r_tx_mem[r_tx_rp];
          r_uart_tx  <= 1'b0;
          r_tx_state <= TX_START;
        end
        TX_START: if (w_tx_tick) begin
          r_uart_tx  <= r_tx_sh[0];
          r_tx_sh    <= r_tx_sh >> 1;
          r_tx_bit   <= '0;
          r_tx_state <= TX_DATA;
        end
        TX_DATA: if (w_tx_tick) begin
          r_tx_bit <= r_tx_bit + 3'd1;
          if (r_tx_bit == 3'd7) begin
            r_uart_tx  <= 1'b1;
            r_tx_state <= TX_STOP;
          end else begin
            r_uart_tx <= r_tx_sh[0];
            r_tx_sh   <= r_tx_sh >> 1;
          end
        end
        default: if (w_tx_tick) r_tx_state <= TX_IDLE;
      endcase
    end
  end
  // RX FIFO storage, written with the completed byte at the stop-bit sample
  always_ff @(posedge clock)
    if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_sh;
  // RX FIFO pointers and occupancy; a pop on the same edge makes room for a push into a full FIFO
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + AW'(1);
      if (w_rx_pop) r_rx_rp <= r_rx_rp + AW'(1);
      r_rx_cnt <= r_rx_cnt + (AW+1)'(w_rx_push) - (AW+1)'(w_rx_pop);
    end
  end
  // RX deserialiser: synchronise the line, mid-bit sampling, sticky overrun and framing flags
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rx_s1      <= 1'b1;
      r_rx_s2      <= 1'b1;
      r_rx_state   <= RX_IDLE;
      r_rx_clk     <= '0;
      r_rx_bit     <= '0;
      r_rx_sh      <= '0;
      r_rx_overrun <= 1'b0;
      r_rx_ferr    <= 1'b0;
    end else begin
      r_rx_s1  <= uart_rx;
      r_rx_s2  <= r_rx_s1;
      r_rx_clk <= (r_rx_state == RX_IDLE || r_rx_state == RX_WAIT || w_rx_samp) ? '0 : r_rx_clk + CW'(1);
      if (w_rx_stop && r_rx_s2 && !w_rx_push) r_rx_overrun <= 1'b1;
      if (w_rx_stop && !r_rx_s2) r_rx_ferr <= 1'b1;
      case (r_rx_state)
        RX_IDLE: if (!r_rx_s2) r_rx_state <= RX_START;
        RX_START: if (w_rx_samp) begin
          r_rx_bit   <= '0;
          r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (w_rx_samp) begin
          r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
          r_rx_bit <= r_rx_bit + 3'd1;
          if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
        end
        RX_STOP: if (w_rx_samp) r_rx_state <= r_rx_s2 ? RX_IDLE : RX_WAIT;
        RX_WAIT: if (r_rx_s2) r_rx_state <= RX_IDLE;
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_uart_bridge.sv
// tb_serial_uart_bridge: directed self-checking bench for the serial UART bridge
module tb_serial_uart_bridge;
  logic clock, reset, rx_drv, loop_en, uart_tx, uart_rx, rx_overrun, rx_frame_err;
  logic [7:0] tx_q[$];
  logic m_prev;
  logic [7:0] m_byte;
  int n_chk, n_err;
  serial_uart_bridge_if hif();
  assign uart_rx = loop_en ? uart_tx : rx_drv;
  serial_uart_bridge #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .host(hif), .uart_rx(uart_rx),
    .uart_tx(uart_tx), .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err)
  );
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send_rx(input logic [7:0] b, input logic stop, input logic pop_at_stop);
    for (int k = 0; k < 160; k++) begin
      rx_drv = k < 16 ? 1'b0 : k < 144 ? b[(k-16)/16] : stop;
      if (k == 154) hif.host_rden = pop_at_stop;
      if (k == 155) hif.host_rden = 1'b0;
      @(negedge clock);
    end
    rx_drv = 1'b1;
    repeat (2) @(negedge clock);
  endtask
  task automatic pop_chk(input logic [7:0] exp);
    chk("rx_head", hif.host_rd_data, exp);
    hif.host_rden = 1'b1;
    @(negedge clock);
    hif.host_rden = 1'b0;
  endtask
  initial begin
    m_prev = 1'b1;
    forever begin
      @(negedge clock);
      if (m_prev && !uart_tx) begin
        repeat (8) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(negedge clock);
          m_byte[i] = uart_tx;
        end
        repeat (16) @(negedge clock);
        tx_q.push_back(m_byte);
      end
      m_prev = uart_tx;
    end
  end
  initial begin
    logic [7:0] v;
    n_chk = 0;
    n_err = 0;
    reset = 1'b0;
    rx_drv = 1'b1;
    loop_en = 1'b0;
    hif.host_wren = 1'b0;
    hif.host_rden = 1'b0;
    hif.host_wr_data = 8'h00;
    repeat (3) @(negedge clock);
    chk("rst_tx", uart_tx, 1);
    chk("rst_valid", hif.host_valid, 0);
    chk("rst_ready", hif.host_ready, 1);
    chk("rst_rdata", hif.host_rd_data, 8'h00);
    chk("rst_ovr", rx_overrun, 0);
    chk("rst_ferr", rx_frame_err, 0);
    reset = 1'b1;
    @(negedge clock);
    v = 8'hA5;
    hif.host_wr_data = v;
    hif.host_wren = 1'b1;
    @(negedge clock);
    hif.host_wren = 1'b0;
    chk("tx_idle_at_push", uart_tx, 1);
    @(negedge clock);
    for (int k = 0; k <= 161; k++) begin
      chk("tx_a5_line", uart_tx, k < 16 ? 1'b0 : k < 144 ? v[(k-16)/16] : 1'b1);
      @(negedge clock);
    end
    tx_q.delete();
    for (int i = 1; i <= 6; i++) begin
      hif.host_wr_data = 8'(i);
      hif.host_wren = 1'b1;
      @(negedge clock);
      chk("tx_ready_fill", hif.host_ready, i < 5);
    end
    hif.host_wren = 1'b0;
    repeat (1200) @(negedge clock);
    chk("tx_frame_count", tx_q.size(), 5);
    for (int i = 0; i < 5; i++) chk("tx_fifo_order", tx_q[i], i + 1);
    chk("tx_ready_drained", hif.host_ready, 1);
    loop_en = 1'b1;
    hif.host_wr_data = 8'h3C;
    hif.host_wren = 1'b1;
    @(negedge clock);
    hif.host_wren = 1'b0;
    for (int i = 0; i < 400 && !hif.host_valid; i++) @(negedge clock);
    chk("loop_valid", hif.host_valid, 1);
    chk("loop_data", hif.host_rd_data, 8'h3C);
    hif.host_rden = 1'b1;
    @(negedge clock);
    hif.host_rden = 1'b0;
    chk("loop_pop_valid", hif.host_valid, 0);
    chk("loop_pop_data", hif.host_rd_data, 8'h00);
    repeat (30) @(negedge clock);
    loop_en = 1'b0;
    repeat (5) @(negedge clock);
    for (int i = 0; i < 4; i++) send_rx(8'(8'h11 + i), 1'b1, 1'b0);
    chk("ovr_before", rx_overrun, 0);
    send_rx(8'h15, 1'b1, 1'b0);
    chk("ovr_set", rx_overrun, 1);
    chk("ovr_valid", hif.host_valid, 1);
    send_rx(8'h16, 1'b1, 1'b1);
    pop_chk(8'h12);
    pop_chk(8'h13);
    pop_chk(8'h14);
    pop_chk(8'h16);
    chk("ovr_empty", hif.host_valid, 0);
    rx_drv = 1'b0;
    repeat (5) @(negedge clock);
    rx_drv = 1'b1;
    repeat (40) @(negedge clock);
    chk("glitch_nopush", hif.host_valid, 0);
    chk("glitch_ferr", rx_frame_err, 0);
    send_rx(8'h55, 1'b0, 1'b0);
    repeat (20) @(negedge clock);
    chk("ferr_nopush", hif.host_valid, 0);
    chk("ferr_set", rx_frame_err, 1);
    rx_drv = 1'b0;
    repeat (200) @(negedge clock);
    rx_drv = 1'b1;
    repeat (5) @(negedge clock);
    chk("hold_low_nopush", hif.host_valid, 0);
    send_rx(8'h7E, 1'b1, 1'b0);
    chk("recover_valid", hif.host_valid, 1);
    pop_chk(8'h7E);
    chk("recover_single", hif.host_valid, 0);
    hif.host_wr_data = 8'hC3;
    hif.host_wren = 1'b1;
    @(negedge clock);
    hif.host_wren = 1'b0;
    repeat (5) @(negedge clock);
    chk("mid_frame_low", uart_tx, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_tx", uart_tx, 1);
    chk("mid_rst_ovr", rx_overrun, 0);
    chk("mid_rst_ferr", rx_frame_err, 0);
    chk("mid_rst_ready", hif.host_ready, 1);
    reset = 1'b1;
    repeat (200) @(negedge clock);
    chk("post_rst_idle", uart_tx, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
